// File: rtl/hilo_pkg.sv
// -----------------------------------------------------------------------------
// hilo_pkg
// Shared definitions for the HI/LO register unit.
//   hilo_op_e     : 3-bit op encoding presented on hilo_acc_unit.op
//   is_acc_op()   : op is one of the multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU)
//   is_sub_op()   : accumulate op subtracts the product (MSUB/MSUBU)
//   is_signed_op(): accumulate op uses a signed multiply (MADD/MSUB)
// -----------------------------------------------------------------------------
package hilo_pkg;

   typedef enum logic [2:0] {
      OP_NOP     = 3'd0,
      OP_WR_BOTH = 3'd1,
      OP_WR_HI   = 3'd2,
      OP_WR_LO   = 3'd3,
      OP_MADD    = 3'd4,
      OP_MADDU   = 3'd5,
      OP_MSUB    = 3'd6,
      OP_MSUBU   = 3'd7
   } hilo_op_e;

   // All accumulate ops live in the upper half of the encoding space.
   function automatic logic is_acc_op(hilo_op_e op);
      return op[2];
   endfunction

   function automatic logic is_sub_op(hilo_op_e op);
      return (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

   function automatic logic is_signed_op(hilo_op_e op);
      return (op == OP_MADD) || (op == OP_MSUB);
   endfunction

endpackage

// File: rtl/hilo_mul.sv
// -----------------------------------------------------------------------------
// hilo_mul
// Stage 1 of the accumulate pipeline: registers the full 2*WIDTH product of
// src_a and src_b, sign- or zero-extended according to is_signed.
// Ports:
//   clk       in  1        clock
//   load      in  1        capture a new product this cycle
//   is_signed in  1        1: signed operands, 0: unsigned operands
//   src_a     in  WIDTH    multiply operand A
//   src_b     in  WIDTH    multiply operand B
//   product   out 2*WIDTH  registered product
// -----------------------------------------------------------------------------
module hilo_mul #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 load,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     src_a,
   input  logic [WIDTH-1:0]     src_b,
   output logic [2*WIDTH-1:0]   product
);

   logic [2*WIDTH-1:0] a_ext;
   logic [2*WIDTH-1:0] b_ext;

   // Extending both operands to 2*WIDTH and keeping the low 2*WIDTH bits of
   // the product gives the exact signed or unsigned result with one multiplier.
   always_comb begin
      a_ext = is_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
      b_ext = is_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
   end

   // NOTE: datapath register without reset; it is only consumed while the
   // top level's s1_valid is set, and that flag is reset.
   always_ff @(posedge clk) begin
      if (load) product <= a_ext * b_ext;
   end

endmodule

// File: rtl/hilo_acc_unit.sv
// -----------------------------------------------------------------------------
// hilo_acc_unit
// Architectural HI/LO registers for the MIPS core. Serves MTHI/MTLO, whole-pair
// writes from MULT/DIV and the MADD/MADDU/MSUB/MSUBU accumulates. Accumulates
// take two cycles: multiply (hilo_mul), then add/subtract and commit.
// Build option: define HILO_MAC_EN to implement the accumulate ops; without it
// ops 4-7 are accepted and dropped, busy is 0 and no multiplier is built.
// Ports:
//   clk       in  1      clock
//   rst       in  1      synchronous active-high reset
//   op_valid  in  1      an op is presented this cycle
//   op        in  3      hilo_op_e encoding
//   hi_i      in  WIDTH  HI write data
//   lo_i      in  WIDTH  LO write data
//   src_a     in  WIDTH  multiply operand A
//   src_b     in  WIDTH  multiply operand B
//   flush     in  1      exception flush, kills an uncommitted accumulate
//   op_ready  out 1      unit can accept an op this cycle
//   busy      out 1      accumulate in flight, HI/LO stale
//   hi_o      out WIDTH  architectural HI
//   lo_o      out WIDTH  architectural LO
// -----------------------------------------------------------------------------
import hilo_pkg::*;

module hilo_acc_unit #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               op_valid,
   input  logic [2:0]         op,
   input  logic [WIDTH-1:0]   hi_i,
   input  logic [WIDTH-1:0]   lo_i,
   input  logic [WIDTH-1:0]   src_a,
   input  logic [WIDTH-1:0]   src_b,
   input  logic               flush,
   output logic               op_ready,
   output logic               busy,
   output logic [WIDTH-1:0]   hi_o,
   output logic [WIDTH-1:0]   lo_o
);

   hilo_op_e             op_e;
   logic                 accept;
   logic                 commit;
   logic [2*WIDTH-1:0]   acc_result;

   assign op_e   = hilo_op_e'(op);
   assign accept = op_valid && op_ready && !flush;

`ifdef HILO_MAC_EN
   logic                 s1_valid;
   logic                 s1_sub;
   logic                 mul_load;
   logic [2*WIDTH-1:0]   product;

   assign mul_load = accept && is_acc_op(op_e);

   hilo_mul #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .load      (mul_load),
      .is_signed (is_signed_op(op_e)),
      .src_a     (src_a),
      .src_b     (src_b),
      .product   (product)
   );

   // s1 lives exactly one cycle: it either commits or is flushed. No new
   // accumulate can load while it is set because op_ready is low.
   always_ff @(posedge clk) begin
      if (rst)           s1_valid <= 1'b0;
      else if (s1_valid) s1_valid <= 1'b0;
      else               s1_valid <= mul_load;
   end

   always_ff @(posedge clk) begin
      if (mul_load) s1_sub <= is_sub_op(op_e);
   end

   assign commit     = s1_valid && !flush;
   // Wraps modulo 2^(2*WIDTH); there is no overflow trap.
   assign acc_result = s1_sub ? ({hi_o, lo_o} - product) : ({hi_o, lo_o} + product);
   assign busy       = s1_valid;
   assign op_ready   = !rst && !s1_valid;
`else
   // Operands only feed the multiplier, which this build omits.
   logic unused_mac;
   assign unused_mac = ^{src_a, src_b};

   assign commit     = 1'b0;
   assign acc_result = {hi_o, lo_o};
   assign busy       = 1'b0;
   assign op_ready   = !rst;
`endif

   // Commit and accept never coincide: accept needs op_ready, which is low
   // whenever s1 holds an accumulate.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_o <= '0;
         lo_o <= '0;
      end else if (commit) begin
         {hi_o, lo_o} <= acc_result;
      end else if (accept) begin
         case (op_e)
            OP_WR_BOTH: begin
               hi_o <= hi_i;
               lo_o <= lo_i;
            end
            OP_WR_HI: hi_o <= hi_i;
            OP_WR_LO: lo_o <= lo_i;
            default:  ;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_acc_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_acc_unit
// Self-checking bench for hilo_acc_unit (WIDTH=32). Follows the HILO_MAC_EN
// build option so it checks either build against the matching expectations.
// The reference model keeps {HI,LO} as one 64-bit number plus at most one
// pending product, updated once per clock from the presented inputs.
// -----------------------------------------------------------------------------
module tb_hilo_acc_unit;

`ifdef HILO_MAC_EN
   localparam bit MAC_EN = 1'b1;
`else
   localparam bit MAC_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] hi_i;
   logic [31:0] lo_i;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        op_ready;
   logic        busy;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [63:0] m_pair;
   logic [63:0] m_prod;
   bit          m_pend;
   bit          m_sub;

   hilo_acc_unit #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .op_valid (op_valid),
      .op       (op),
      .hi_i     (hi_i),
      .lo_i     (lo_i),
      .src_a    (src_a),
      .src_b    (src_b),
      .flush    (flush),
      .op_ready (op_ready),
      .busy     (busy),
      .hi_o     (hi_o),
      .lo_o     (lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1);
   end

   // Product of two 32-bit numbers as an exact 64-bit value.
   function automatic logic [63:0] full_product(input logic [31:0] a, input logic [31:0] b,
                                                input bit signed_op);
      longint sa;
      longint sb;
      if (signed_op) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   // Advance the model by one clock edge using the inputs currently presented.
   task automatic model_edge();
      if (rst) begin
         m_pair = 64'd0;
         m_pend = 1'b0;
      end else if (m_pend) begin
         if (!flush) m_pair = m_sub ? m_pair - m_prod : m_pair + m_prod;
         m_pend = 1'b0;
      end else if (op_valid && !flush) begin
         case (op)
            3'd1: m_pair = {hi_i, lo_i};
            3'd2: m_pair[63:32] = hi_i;
            3'd3: m_pair[31:0] = lo_i;
            3'd4, 3'd5, 3'd6, 3'd7: begin
               if (MAC_EN) begin
                  m_pend = 1'b1;
                  m_sub  = (op == 3'd6) || (op == 3'd7);
                  m_prod = full_product(src_a, src_b, (op == 3'd4) || (op == 3'd6));
               end
            end
            default: ;
         endcase
      end
   endtask

   // Present one cycle of inputs, clock it, and sample #1 after the edge.
   task automatic cycle(input bit r, input bit v, input logic [2:0] o,
                        input logic [31:0] h, input logic [31:0] l,
                        input logic [31:0] a, input logic [31:0] b, input bit f);
      rst = r; op_valid = v; op = o; hi_i = h; lo_i = l; src_a = a; src_b = b; flush = f;
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      cycle(1'b1, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);
      checks++;
      if (op_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready_low: got %b expected 0", op_ready);
      end
      rst = 1'b0; op_valid = 1'b0;
      #1;
      checks++;
      if ({hi_o, lo_o, busy, op_ready} !== {64'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_release: got hi=%h lo=%h busy=%b ready=%b expected 0/0/0/1",
                  hi_o, lo_o, busy, op_ready);
      end
   endtask

   task automatic test_write();
      cycle(1'b0, 1'b1, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 1'b0);
      checks++;
      if ({hi_o, lo_o} !== 64'h12345678_9ABCDEF0) begin
         errors++; $display("FAIL wr_both: got %h_%h expected 12345678_9abcdef0", hi_o, lo_o);
      end
      cycle(1'b0, 1'b1, 3'd2, 32'hDEAD_BEEF, 32'h5555_5555, 32'd0, 32'd0, 1'b0);
      checks++;
      if ({hi_o, lo_o} !== 64'hDEADBEEF_9ABCDEF0) begin
         errors++; $display("FAIL wr_hi: got %h_%h expected deadbeef_9abcdef0", hi_o, lo_o);
      end
   endtask

   task automatic test_madd();
      logic [63:0] exp_pair;
      exp_pair = MAC_EN ? 64'hFFFFFFFF_FFFFFFFA : 64'd0;
      cycle(1'b0, 1'b1, 3'd1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      cycle(1'b0, 1'b1, 3'd4, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
      checks++;
      if ({busy, op_ready} !== {MAC_EN, !MAC_EN}) begin
         errors++;
         $display("FAIL madd_busy: got busy=%b ready=%b expected busy=%b ready=%b",
                  busy, op_ready, MAC_EN, !MAC_EN);
      end
      idle();
      checks++;
      if ({hi_o, lo_o} !== exp_pair) begin
         errors++; $display("FAIL madd_result: got %h_%h expected %h", hi_o, lo_o, exp_pair);
      end
   endtask

   task automatic test_unsigned();
      logic [63:0] exp_pair;
      exp_pair = MAC_EN ? 64'hFFFFFFFE_00000001 : 64'd0;
      cycle(1'b0, 1'b1, 3'd1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      cycle(1'b0, 1'b1, 3'd5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      idle();
      checks++;
      if ({hi_o, lo_o} !== exp_pair) begin
         errors++; $display("FAIL maddu_result: got %h_%h expected %h", hi_o, lo_o, exp_pair);
      end
      cycle(1'b0, 1'b1, 3'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      idle();
      checks++;
      if ({hi_o, lo_o} !== 64'd0) begin
         errors++; $display("FAIL msubu_result: got %h_%h expected 0", hi_o, lo_o);
      end
   endtask

   task automatic test_flush();
      cycle(1'b0, 1'b1, 3'd1, 32'h1, 32'h2, 32'd0, 32'd0, 1'b0);
      cycle(1'b0, 1'b1, 3'd4, 32'd0, 32'd0, 32'd5, 32'd7, 1'b0);
      cycle(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
      checks++;
      if ({hi_o, lo_o, busy, op_ready} !== {32'h1, 32'h2, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL flush_kill: got hi=%h lo=%h busy=%b ready=%b expected 1/2/0/1",
                  hi_o, lo_o, busy, op_ready);
      end
      // An op presented together with flush is ignored.
      cycle(1'b0, 1'b1, 3'd3, 32'd0, 32'h77, 32'd0, 32'd0, 1'b1);
      checks++;
      if (lo_o !== 32'h2) begin
         errors++; $display("FAIL flush_op_ignored: got lo=%h expected 2", lo_o);
      end
      cycle(1'b0, 1'b1, 3'd3, 32'd0, 32'h33, 32'd0, 32'd0, 1'b0);
      checks++;
      if ({hi_o, lo_o} !== {32'h1, 32'h33}) begin
         errors++; $display("FAIL flush_then_wr_lo: got %h_%h expected 00000001_00000033", hi_o, lo_o);
      end
   endtask

   task automatic test_blocked();
      // From {1,0x33}: MADD 2*3 adds 6, then WR_LO 0xAA is held off one cycle.
      logic [63:0] exp_pair;
      exp_pair = MAC_EN ? 64'h00000001_000000AA : 64'h00000001_000000AA;
      cycle(1'b0, 1'b1, 3'd4, 32'd0, 32'd0, 32'd2, 32'd3, 1'b0);
      rst = 1'b0; op_valid = 1'b1; op = 3'd3; lo_i = 32'hAA; flush = 1'b0;
      #1;
      checks++;
      if (op_ready !== !MAC_EN) begin
         errors++; $display("FAIL blocked_ready: got %b expected %b", op_ready, !MAC_EN);
      end
      cycle(1'b0, 1'b1, 3'd3, 32'd0, 32'hAA, 32'd0, 32'd0, 1'b0);
      if (MAC_EN) begin
         checks++;
         if ({hi_o, lo_o, op_ready} !== {32'h1, 32'h39, 1'b1}) begin
            errors++;
            $display("FAIL blocked_commit: got %h_%h ready=%b expected 00000001_00000039 ready=1",
                     hi_o, lo_o, op_ready);
         end
         cycle(1'b0, 1'b1, 3'd3, 32'd0, 32'hAA, 32'd0, 32'd0, 1'b0);
      end
      checks++;
      if ({hi_o, lo_o} !== exp_pair) begin
         errors++; $display("FAIL blocked_accept: got %h_%h expected %h", hi_o, lo_o, exp_pair);
      end
   endtask

   task automatic test_back_to_back();
      cycle(1'b0, 1'b1, 3'd1, 32'hA0A0_A0A0, 32'hB0B0_B0B0, 32'd0, 32'd0, 1'b0);
      cycle(1'b0, 1'b1, 3'd3, 32'h0, 32'hC0C0_C0C0, 32'd0, 32'd0, 1'b0);
      cycle(1'b0, 1'b1, 3'd2, 32'hD0D0_D0D0, 32'h0, 32'd0, 32'd0, 1'b0);
      cycle(1'b0, 1'b1, 3'd0, 32'h1111_1111, 32'h2222_2222, 32'd0, 32'd0, 1'b0);
      checks++;
      if ({hi_o, lo_o} !== 64'hD0D0D0D0_C0C0C0C0) begin
         errors++; $display("FAIL back_to_back: got %h_%h expected d0d0d0d0_c0c0c0c0", hi_o, lo_o);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 2000; i++) begin
         cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80),
               3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom,
               ($urandom_range(0, 99) < 10));
         checks++;
         if ({hi_o, lo_o, busy, op_ready} !== {m_pair, m_pend, !rst && !m_pend}) begin
            errors++;
            $display("FAIL random[%0d]: got hi=%h lo=%h busy=%b ready=%b expected %h busy=%b ready=%b",
                     i, hi_o, lo_o, busy, op_ready, m_pair, m_pend, !rst && !m_pend);
         end
      end
   endtask

   initial begin
      m_pair = 64'd0; m_prod = 64'd0; m_pend = 1'b0; m_sub = 1'b0;
      rst = 1'b1; op_valid = 1'b0; op = 3'd0; flush = 1'b0;
      hi_i = 32'd0; lo_i = 32'd0; src_a = 32'd0; src_b = 32'd0;
      @(posedge clk);
      #1;
      test_reset();
      test_write();
      test_madd();
      test_unsigned();
      test_flush();
      test_blocked();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hilo_acc_unit.md
# hilo_acc_unit

Parametrised HI/LO register unit for the MIPS core: it holds the architectural HI and LO registers and serves MTHI, MTLO, whole-pair writes from MULT/DIV, and the MADD/MADDU/MSUB/MSUBU multiply-accumulate ops. Accumulates run through a 2-stage internal pipeline: multiply, then add/subtract and commit. The unit sits beside the EX/MEM stages. It exposes `busy` and `op_ready` so the pipeline control stalls MFHI/MFLO and new HI/LO ops while an accumulate is in flight.

## Interface
Parameters:
- `WIDTH`, default 32: width of HI, LO and the multiply operands.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `op_valid`  in  1: an op is presented this cycle.
- `op`  in  3: `hilo_op_e` encoding.
- `hi_i`  in  WIDTH: HI write data.
- `lo_i`  in  WIDTH: LO write data.
- `src_a`  in  WIDTH: multiply operand A.
- `src_b`  in  WIDTH: multiply operand B.
- `flush`  in  1: exception flush; kills an uncommitted accumulate.
- `op_ready`  out  1: the unit can accept an op this cycle.
- `busy`  out  1: an accumulate is in flight, so HI/LO are stale.
- `hi_o`  out  WIDTH: architectural HI.
- `lo_o`  out  WIDTH: architectural LO.

## Operation
- Op encodings:
  - 0 NOP.
  - 1 WR_BOTH.
  - 2 WR_HI.
  - 3 WR_LO.
  - 4 MADD (signed).
  - 5 MADDU (unsigned).
  - 6 MSUB (signed).
  - 7 MSUBU (unsigned).
- An op is accepted when `op_valid && op_ready && !flush`.
- WR_BOTH loads both registers. WR_HI loads HI only and LO holds. WR_LO loads LO only and HI holds.
- Stage 1 (s1) of an accumulate:
  - Registers the 2·WIDTH product of `src_a` and `src_b`, signed for MADD/MSUB and unsigned for MADDU/MSUBU.
  - Records add/sub and sets `s1_valid`.
- Stage 2 commits `{hi_o,lo_o} <= {hi_o,lo_o} ± product`, computed modulo 2^(2·WIDTH). There is no overflow trap.
- `op_ready = !rst && !s1_valid`. At most one accumulate is in flight.
- `busy = s1_valid`.
- `flush` with `s1_valid` set clears `s1_valid`; HI/LO are not modified.
- `flush` in the same cycle as `op_valid` causes the op to be ignored.
- NOP is accepted and has no effect.

## Timing
- Reset values: `hi_o` = 0, `lo_o` = 0, `s1_valid` = 0 (so `busy` = 0), `op_ready` = 0 while `rst` is high.
- `rst` wins over `flush` and over any op, including reset asserted mid-accumulate: s1 is dropped and HI/LO are zeroed.
- Write ops accepted at edge N are visible on `hi_o`/`lo_o` in cycle N+1 (1-cycle latency).
- Accumulate accepted at edge N:
  - `busy`=1 and `op_ready`=0 during cycle N+1.
  - Commit at edge N+1; result visible in cycle N+2.
  - The next op can be accepted at edge N+2, so peak accumulate throughput is one per 2 cycles.
- Back-to-back write ops are accepted every cycle, and the last one wins.
- A `flush` in cycle N+1 blocks the commit at edge N+1.

## Configuration
- `HILO_MAC_EN` defined:
  - Accumulate ops 4–7 are implemented as above.
  - The multiplier and s1 registers are instantiated.
- `HILO_MAC_EN` undefined:
  - Ops 4–7 are accepted and dropped with no state change.
  - `busy` is tied to 0 and `op_ready = !rst`.
  - No multiplier is synthesised.
  - Write ops behave identically in both builds.

## Structure
- `hilo_pkg` holds the `hilo_op_e` enum (3-bit, encodings above) and the helper function `is_acc_op(op)`.
- Sub-module `hilo_mul`:
  - Parametrised by WIDTH.
  - Takes `src_a`, `src_b`, a signed flag and a load enable.
  - Produces the registered 2·WIDTH product (stage 1).
  - Is instantiated only under `HILO_MAC_EN`.
- The top level owns the HI/LO registers, the commit adder/subtractor, and the `s1_valid`/flush control.

## Test plan
All scenarios use WIDTH=32.
- **Reset:** hold `rst` 2 cycles, then release. Required: `hi_o`=`lo_o`=0, `busy`=0, `op_ready`=1 in the first cycle after release.
- **Whole-pair write:** WR_BOTH with hi=0x12345678, lo=0x9ABCDEF0, then WR_HI with hi=0xDEADBEEF. Required: after the first op the pair reads 0x12345678/0x9ABCDEF0; after the second, `hi_o`=0xDEADBEEF and `lo_o` is unchanged at 0x9ABCDEF0.
- **Signed MADD:** from HI/LO = 0, MADD with a=0xFFFFFFFE (−2), b=3 at edge N. Required: `op_ready`=0 and `busy`=1 in cycle N+1; `{hi,lo}`=0xFFFFFFFF_FFFFFFFA in cycle N+2.
- **Unsigned MADDU/MSUBU:** from 0, MADDU with a=b=0xFFFFFFFF gives 0xFFFFFFFE_00000001; a following MSUBU with the same operands returns `{hi,lo}` to 0.
- **Flush:** HI/LO = 0x1/0x2, MADD a=5 b=7, `flush` in the next cycle. Required: HI/LO stay 0x1/0x2, `busy`=0 the following cycle, and the next WR_LO is accepted normally.
- **Blocked op while busy:** WR_LO with lo=0xAA presented in the busy cycle after an accumulate. Required: it is held off (`op_ready`=0), accepted one cycle later, and overwrites LO after the accumulate commit.
